// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with a start/stop toggle, a clock-cycle prescaler,
// synchronous clear and a one-cycle wrap pulse on full-range roll-over.
module bcd_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  output logic [3:0] bcdout [DIGITS-1:0],
  output logic       running,
  output logic       wrap
);

  localparam logic PAUSED = 1'b0;
  localparam logic RUN    = 1'b1;

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  logic          state;
  logic          prev;
  logic [PW-1:0] presc;
  logic          ss_edge;
  logic          tick;
  logic          carry;
  logic [3:0]    next_digits [DIGITS-1:0];

  assign ss_edge = start_stop & ~prev;
  assign tick    = (state == RUN) && (presc == PRESC_TOP);

  // Ripple carry/borrow through the digits; carry left over after the last digit
  // means every digit rolled, i.e. a full-range wrap.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      next_digits[i] = bcdout[i];
      if (carry) begin
        if (dir) begin
          if (bcdout[i] == 4'd9) begin
            next_digits[i] = 4'd0;
          end else begin
            next_digits[i] = bcdout[i] + 4'd1;
            carry          = 1'b0;
          end
        end else begin
          if (bcdout[i] == 4'd0) begin
            next_digits[i] = 4'd9;
          end else begin
            next_digits[i] = bcdout[i] - 4'd1;
            carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= PAUSED;
      prev    <= 1'b0;
      presc   <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
      // NOTE: the digit array is a handful of flops, not a RAM, so it is reset.
      for (int i = 0; i < DIGITS; i++) bcdout[i] <= 4'd0;
    end else begin
      prev    <= start_stop;
      running <= (state == RUN);
      wrap    <= 1'b0;
      if (ss_edge) state <= (state == RUN) ? PAUSED : RUN;

      if (clear) begin
        presc <= '0;
        for (int i = 0; i < DIGITS; i++) bcdout[i] <= 4'd0;
      end else begin
        if (state == RUN) presc <= (presc == PRESC_TOP) ? '0 : presc + 1'b1;
        if (tick) begin
          for (int i = 0; i < DIGITS; i++) bcdout[i] <= next_digits[i];
          wrap <= carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Scoreboard bench for bcd_counter: three 2-digit instances (TICK_DIV 3, 1, 4) driven
// by directed stimulus; hand-derived expectations are queued per cycle and checked.
module tb_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] ss, clr, dr;
  logic [3:0] bcd_a [1:0];
  logic [3:0] bcd_b [1:0];
  logic [3:0] bcd_c [1:0];
  logic [2:0] run, wr;

  bcd_counter #(.DIGITS(2), .TICK_DIV(3)) dut_a (
    .clk(clk), .rst(rst), .start_stop(ss[0]), .clear(clr[0]), .dir(dr[0]),
    .bcdout(bcd_a), .running(run[0]), .wrap(wr[0])
  );
  bcd_counter #(.DIGITS(2), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start_stop(ss[1]), .clear(clr[1]), .dir(dr[1]),
    .bcdout(bcd_b), .running(run[1]), .wrap(wr[1])
  );
  bcd_counter #(.DIGITS(2), .TICK_DIV(4)) dut_c (
    .clk(clk), .rst(rst), .start_stop(ss[2]), .clear(clr[2]), .dir(dr[2]),
    .bcdout(bcd_c), .running(run[2]), .wrap(wr[2])
  );

  typedef struct {
    int         at;
    int         dut;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       r;
    logic       w;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input int dut, input int val,
                           input logic r, input logic w, input string name);
    exp_t e;
    e.at   = at;
    e.dut  = dut;
    e.d1   = 4'(val / 10);
    e.d0   = 4'(val % 10);
    e.r    = r;
    e.w    = w;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation due in the current cycle.
  initial begin
    exp_t       e;
    logic [3:0] a1, a0;
    logic       ar, aw;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin a1 = bcd_a[1]; a0 = bcd_a[0]; ar = run[0]; aw = wr[0]; end
          1:       begin a1 = bcd_b[1]; a0 = bcd_b[0]; ar = run[1]; aw = wr[1]; end
          default: begin a1 = bcd_c[1]; a0 = bcd_c[0]; ar = run[2]; aw = wr[2]; end
        endcase
        tests++;
        if (e.at != cyc || a1 !== e.d1 || a0 !== e.d0 || ar !== e.r || aw !== e.w) begin
          fails++;
          $display("FAIL %s dut%0d cyc %0d (due %0d): got %0d%0d run=%b wrap=%b, want %0d%0d run=%b wrap=%b",
                   e.name, e.dut, cyc, e.at, a1, a0, ar, aw, e.d1, e.d0, e.r, e.w);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: timeout at cyc %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int s;
    rst = 1'b1; ss = '0; clr = '0; dr = '0;
    step(2);
    for (int d = 0; d < 3; d++) expect_at(cyc, d, 0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // Count up on the TICK_DIV=3 instance: steps every 3 cycles, 10 after 10 ticks.
    ss[0] = 1'b1; dr[0] = 1'b1;
    for (int c = 3; c <= 33; c++) expect_at(c, 0, (c - 3) / 3, c != 3, 1'b0, "a_count");
    step(31);

    // Clear in the tick cycle at 47 beats the tick.
    while (cyc < 146) step(1);
    expect_at(146, 0, 47, 1'b1, 1'b0, "d_pre");
    clr[0] = 1'b1;
    step(1);
    expect_at(147, 0, 0, 1'b1, 1'b0, "d_clear");
    clr[0] = 1'b0;
    expect_at(149, 0, 0, 1'b1, 1'b0, "d_hold");
    expect_at(150, 0, 1, 1'b1, 1'b0, "d_resume");

    // Reset in the tick cycle at 35 with start_stop held high.
    while (cyc < 254) step(1);
    expect_at(254, 0, 35, 1'b1, 1'b0, "e_pre");
    rst = 1'b1;
    step(1);
    for (int d = 0; d < 3; d++) expect_at(255, d, 0, 1'b0, 1'b0, "e_reset");
    rst = 1'b0;
    expect_at(256, 0, 0, 1'b0, 1'b0, "e_first");
    expect_at(257, 0, 0, 1'b1, 1'b0, "e_run");
    expect_at(259, 0, 1, 1'b1, 1'b0, "e_tick");
    step(4);

    // TICK_DIV=4: pause with prescaler at 2, hold, resume, dir wiggle between ticks.
    t = cyc;
    ss[2] = 1'b1; dr[2] = 1'b1;
    expect_at(t + 4, 2, 0, 1'b1, 1'b0, "c_pre");
    expect_at(t + 5, 2, 1, 1'b1, 1'b0, "c_tick1");
    step(5); ss[2] = 1'b0;
    step(1); ss[2] = 1'b1;
    expect_at(t + 7, 2, 1, 1'b1, 1'b0, "c_pause");
    for (int k = 8; k <= 17; k++) expect_at(t + k, 2, 1, 1'b0, 1'b0, "c_hold");
    expect_at(t + 18, 2, 1, 1'b1, 1'b0, "c_resume");
    expect_at(t + 19, 2, 2, 1'b1, 1'b0, "c_tick2");
    step(9); ss[2] = 1'b0;
    step(1); ss[2] = 1'b1;
    step(4); dr[2] = 1'b0;
    step(1); dr[2] = 1'b1;
    expect_at(t + 22, 2, 2, 1'b1, 1'b0, "c_dir_between");
    expect_at(t + 23, 2, 3, 1'b1, 1'b0, "c_dir_up");
    step(2);

    // TICK_DIV=1: up through 98, 99 to 00 with wrap, then down to 99 with wrap, 10 to 09.
    s = cyc;
    ss[1] = 1'b1; dr[1] = 1'b1;
    for (int k = 0; k <= 100; k++) expect_at(s + 1 + k, 1, k % 100, k != 0, k == 100, "b_up");
    step(101);
    dr[1] = 1'b0;
    for (int j = 1; j <= 91; j++) expect_at(s + 101 + j, 1, (100 - j) % 100, 1'b1, j == 1, "b_down");
    step(91);
    ss[1] = 1'b0;
    step(1); ss[1] = 1'b1;
    // Stop edge coinciding with a tick applies the tick, then holds.
    expect_at(s + 193, 1, 8, 1'b1, 1'b0, "b_pre_stop");
    expect_at(s + 194, 1, 7, 1'b1, 1'b0, "b_stop_tick");
    expect_at(s + 195, 1, 7, 1'b0, 1'b0, "b_stopped");
    expect_at(s + 196, 1, 7, 1'b0, 1'b0, "b_held");
    step(4);

    step(3);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
